// File: rtl/adc_idly_pkg.sv
// Shared definitions for the ADC IDELAYE3 tap loader.
//   IDLY_TAP_W        width of an IDELAYE3 CNTVALUEIN/CNTVALUEOUT tap value
//   REG_OFS_DLY_VAL   PS register offset carrying the tap value (0xA0000020)
//   REG_OFS_DLY_STR   PS register offset carrying the strobe level (0xA0000024)
//   idly_state_e      loader sequence states
//   max_int()         elaboration-time helper for sizing counters
package adc_idly_pkg;

  localparam int IDLY_TAP_W = 9;

  localparam logic [7:0] REG_OFS_DLY_VAL = 8'h20;
  localparam logic [7:0] REG_OFS_DLY_STR = 8'h24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VTC_OFF = 3'd1,
    LOAD    = 3'd2,
    SETTLE  = 3'd3,
    CHECK   = 3'd4,
    VTC_ON  = 3'd5
  } idly_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_idelay_loader_edge_det.sv
// Registered rising-edge detector for the PS strobe level.
//   clk   in   clock
//   rstn  in   synchronous active-low reset
//   din   in   level input
//   rise  out  one-cycle registered pulse after a 0->1 transition of din
// The detector is disarmed for the first cycle after reset so that a level
// already high when reset releases only primes the history register and is
// not mistaken for an edge.
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic armed;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      din_q <= 1'b0;
      armed <= 1'b0;
      rise  <= 1'b0;
    end else begin
      din_q <= din;
      armed <= 1'b1;
      rise  <= din & ~din_q & armed;
    end
  end

endmodule

// File: rtl/adc_idelay_loader.sv
// IDELAYE3 tap loader for the ADC LVDS data lanes.
// A rising edge of the PS strobe captures the tap value and lane mask, drops
// EN_VTC on the selected lanes, pulses LOAD once, waits for the delay line to
// settle and re-enables VTC tracking.
//   clk               in   register/IDELAY control clock
//   rstn              in   synchronous active-low reset
//   dly_val           in   tap value from PS register
//   dly_str           in   strobe level from PS register
//   lane_mask         in   lanes to update (1 = update)
//   idly_cntvaluein   out  tap value to every IDELAYE3 CNTVALUEIN
//   idly_load         out  per-lane LOAD
//   idly_en_vtc       out  per-lane EN_VTC
//   idly_cntvalueout  in   per-lane CNTVALUEOUT (readback build only)
//   busy              out  sequence in progress
//   done              out  one-cycle pulse at sequence end
//   str_miss          out  sticky: strobe edge arrived while busy
//   rb_err            out  sticky readback mismatch
// Optional feature: define IDLY_READBACK_EN to add a one-cycle CHECK state
// that compares CNTVALUEOUT of the masked lanes with the loaded value.
module adc_idelay_loader
  import adc_idly_pkg::*;
#(
  parameter int NUM_LANES   = 16,
  parameter int VTC_WAIT    = 10,
  parameter int SETTLE_WAIT = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [IDLY_TAP_W-1:0]           dly_val,
  input  logic                            dly_str,
  input  logic [NUM_LANES-1:0]            lane_mask,
  output logic [IDLY_TAP_W-1:0]           idly_cntvaluein,
  output logic [NUM_LANES-1:0]            idly_load,
  output logic [NUM_LANES-1:0]            idly_en_vtc,
  input  logic [IDLY_TAP_W*NUM_LANES-1:0] idly_cntvalueout,
  output logic                            busy,
  output logic                            done,
  output logic                            str_miss,
  output logic                            rb_err
);

  localparam int CNT_MAX = max_int(VTC_WAIT, SETTLE_WAIT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] VTC_LAST    = CNT_W'(VTC_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WAIT - 1);

  // Counter parks at its terminal count instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_TOP) ? c : c + CNT_W'(1);
  endfunction

  idly_state_e           state;
  idly_state_e           state_nx;
  logic [CNT_W-1:0]      cnt;
  logic [IDLY_TAP_W-1:0] val_q;
  logic [NUM_LANES-1:0]  mask_q;
  logic                  str_rise;
  logic                  accept;

  edge_det u_edge_det (
    .clk  (clk),
    .rstn (rstn),
    .din  (dly_str),
    .rise (str_rise)
  );

  assign accept = str_rise && (state == IDLE);

  // State register; the wait counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : sat_inc(cnt);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = VTC_OFF;
      VTC_OFF: if (cnt == VTC_LAST) state_nx = LOAD;
      LOAD:    state_nx = SETTLE;
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
`ifdef IDLY_READBACK_EN
          state_nx = CHECK;
`else
          state_nx = VTC_ON;
`endif
        end
      end
      CHECK:   state_nx = VTC_ON;
      VTC_ON:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == VTC_ON);
    idly_load   = '0;
    idly_en_vtc = '1;
    case (state)
      VTC_OFF, SETTLE, CHECK: idly_en_vtc = ~mask_q;
      LOAD: begin
        idly_en_vtc = ~mask_q;
        idly_load   = mask_q;
      end
      default: ;
    endcase
  end

  // Captured request; held for the whole sequence and kept afterwards so the
  // tap bus keeps showing the last loaded value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      val_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      val_q  <= dly_val;
      mask_q <= lane_mask;
    end
  end

  assign idly_cntvaluein = val_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      str_miss <= 1'b0;
    end else if (accept) begin
      str_miss <= 1'b0;
    end else if (str_rise) begin
      str_miss <= 1'b1;
    end
  end

`ifdef IDLY_READBACK_EN
  logic rb_mismatch;

  always_comb begin
    rb_mismatch = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask_q[i] && (idly_cntvalueout[i*IDLY_TAP_W +: IDLY_TAP_W] != val_q)) begin
        rb_mismatch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rb_err <= 1'b0;
    end else if (accept) begin
      rb_err <= 1'b0;
    end else if ((state == CHECK) && rb_mismatch) begin
      rb_err <= 1'b1;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = ^idly_cntvalueout;
  assign rb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_adc_idelay_loader.sv
// Testbench for adc_idelay_loader (NUM_LANES=16, VTC_WAIT=10, SETTLE_WAIT=8).
// A cycle-level reference model tracks the sequence as an offset into a
// fixed timeline and predicts every output; a compare process checks the DUT
// against it each cycle. Directed scenarios pin the timeline with literal
// values, then a randomized phase exercises strobes, masks and resets.
// Build with IDLY_READBACK_EN defined to cover the readback variant.
module tb_adc_idelay_loader;
  import adc_idly_pkg::*;

  localparam int NL = 16;
  localparam int VW = 10;
  localparam int SW = 8;
`ifdef IDLY_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  // Offset of the VTC_ON cycle within a sequence (offset 0 = first VTC_OFF cycle).
  localparam int L = VW + 1 + SW + RB;

  logic               tb_ACLK;
  logic               rstn;
  logic [8:0]         dly_val;
  logic               dly_str;
  logic [NL-1:0]      lane_mask;
  logic [8:0]         idly_cntvaluein;
  logic [NL-1:0]      idly_load;
  logic [NL-1:0]      idly_en_vtc;
  logic [9*NL-1:0]    idly_cntvalueout;
  logic               busy;
  logic               done;
  logic               str_miss;
  logic               rb_err;

  adc_idelay_loader #(
    .NUM_LANES   (NL),
    .VTC_WAIT    (VW),
    .SETTLE_WAIT (SW)
  ) dut (
    .clk              (tb_ACLK),
    .rstn             (rstn),
    .dly_val          (dly_val),
    .dly_str          (dly_str),
    .lane_mask        (lane_mask),
    .idly_cntvaluein  (idly_cntvaluein),
    .idly_load        (idly_load),
    .idly_en_vtc      (idly_en_vtc),
    .idly_cntvalueout (idly_cntvalueout),
    .busy             (busy),
    .done             (done),
    .str_miss         (str_miss),
    .rb_err           (rb_err)
  );

  initial begin
    tb_ACLK = 1'b0;
    forever #5 tb_ACLK = ~tb_ACLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_live  = 1'b0;
  bit            m_busy  = 1'b0;
  int            m_k     = 0;
  logic [8:0]    m_val   = '0;
  logic [NL-1:0] m_mask  = '0;
  bit            m_miss  = 1'b0;
  bit            m_rb    = 1'b0;
  bit            m_prev  = 1'b0;
  bit            m_armed = 1'b0;
  bit            m_pend  = 1'b0;

  int            corrupt_lane = -1;
  logic [8:0]    corrupt_val  = '0;

  // Lane readback: every lane reports the loaded value unless corrupted.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      idly_cntvalueout[i*9 +: 9] = (i == corrupt_lane) ? corrupt_val : m_val;
    end
  end

  always @(posedge tb_ACLK) begin
    bit start;
    bit bad;
    if (!rstn) begin
      m_live = 1'b1; m_busy = 1'b0; m_k = 0; m_val = '0; m_mask = '0;
      m_miss = 1'b0; m_rb = 1'b0; m_prev = 1'b0; m_armed = 1'b0; m_pend = 1'b0;
    end else begin
      start = 1'b0;
      if (m_pend) begin
        if (m_busy) m_miss = 1'b1;
        else        start  = 1'b1;
      end
      if (m_busy) begin
        if (RB == 1 && m_k == L - 1) begin
          bad = 1'b0;
          for (int i = 0; i < NL; i++)
            if (m_mask[i] && idly_cntvalueout[i*9 +: 9] != m_val) bad = 1'b1;
          if (bad) m_rb = 1'b1;
        end
        if (m_k == L) m_busy = 1'b0;
        else          m_k++;
      end
      if (start) begin
        m_busy = 1'b1; m_k = 0; m_val = dly_val; m_mask = lane_mask;
        m_miss = 1'b0; m_rb = 1'b0;
      end
      m_pend  = dly_str && !m_prev && m_armed;
      m_prev  = dly_str;
      m_armed = 1'b1;
    end
  end

  always @(negedge tb_ACLK) begin
    logic [NL-1:0] e_en;
    logic [NL-1:0] e_ld;
    if (m_live) begin
      e_en = (m_busy && m_k < L) ? ~m_mask : '1;
      e_ld = (m_busy && m_k == VW) ? m_mask : '0;
      chk("model_busy",  32'(busy),            32'(m_busy));
      chk("model_done",  32'(done),            32'(m_busy && m_k == L));
      chk("model_en_vtc",32'(idly_en_vtc),     32'(e_en));
      chk("model_load",  32'(idly_load),       32'(e_ld));
      chk("model_cval",  32'(idly_cntvaluein), 32'(m_val));
      chk("model_miss",  32'(str_miss),        32'(m_miss));
      chk("model_rberr", 32'(rb_err),          32'(m_rb));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic run_seq(input logic [8:0] v, input logic [NL-1:0] m, input int miss_at,
                         output int lat, output int lo_cnt, output logic [NL-1:0] ld,
                         output logic [8:0] cv, output int done_cnt,
                         output logic [NL-1:0] en_and, output logic [NL-1:0] ld_or);
    bit seen;
    lat = -1; lo_cnt = 0; ld = '0; cv = '0; done_cnt = 0; en_and = '1; ld_or = '0;
    seen = 1'b0;
    @(posedge tb_ACLK); #1;
    dly_val = v; lane_mask = m; dly_str = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(negedge tb_ACLK);
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = n;
      end
      if (idly_load != '0 && !seen) begin
        seen = 1'b1; ld = idly_load; cv = idly_cntvaluein;
      end
      if (!seen && busy && idly_en_vtc == ~m) lo_cnt++;
      en_and &= idly_en_vtc;
      ld_or  |= idly_load;
      @(posedge tb_ACLK); #1;
      if (n == 2) dly_str = 1'b0;
      if (n == 4) begin dly_val = ~v; lane_mask = ~m; end
      if (n == miss_at)     dly_str = 1'b1;
      if (n == miss_at + 2) dly_str = 1'b0;
    end
  endtask

  initial begin
    int lat, lo, dc;
    logic [NL-1:0] ld, en_and, ld_or;
    logic [8:0] cv;
    bit busy_seen;

    rstn = 1'b0; dly_val = '0; dly_str = 1'b0; lane_mask = '0;
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_en_vtc",32'(idly_en_vtc), 32'hFFFF);
    chk("rst_load",  32'(idly_load), 32'd0);
    chk("rst_cval",  32'(idly_cntvaluein), 32'd0);
    chk("rst_miss",  32'(str_miss), 32'd0);
    chk("rst_rberr", 32'(rb_err), 32'd0);
    @(posedge tb_ACLK); #1;
    rstn = 1'b1;
    repeat (3) @(posedge tb_ACLK);

    // Full mask, value 3
    run_seq(9'h003, 16'hFFFF, -10, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("full_latency", 32'(lat), 32'(21 + RB));
    chk("full_vtc_low_cycles", 32'(lo), 32'd10);
    chk("full_load", 32'(ld), 32'hFFFF);
    chk("full_cval_at_load", 32'(cv), 32'h003);
    chk("full_done_count", 32'(dc), 32'd1);
    chk("full_en_vtc_after", 32'(idly_en_vtc), 32'hFFFF);
    chk("full_busy_after", 32'(busy), 32'd0);
    chk("full_cval_held", 32'(idly_cntvaluein), 32'h003);

    // Partial mask: lanes 0 and 2 only
    run_seq(9'h1FF, 16'h0005, -10, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("part_load", 32'(ld), 32'h0005);
    chk("part_cval_at_load", 32'(cv), 32'h1FF);
    chk("part_unmasked_en_vtc", 32'(en_and & 16'hFFFA), 32'hFFFA);
    chk("part_load_or", 32'(ld_or), 32'h0005);
    chk("part_vtc_low_cycles", 32'(lo), 32'd10);
    chk("part_latency", 32'(lat), 32'(21 + RB));

    // Second strobe edge five cycles into the sequence
    run_seq(9'h0AA, 16'h00F0, 6, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("miss_done_count", 32'(dc), 32'd1);
    chk("miss_latency", 32'(lat), 32'(21 + RB));
    chk("miss_sticky", 32'(str_miss), 32'd1);
    run_seq(9'h055, 16'h1234, -10, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("miss_cleared", 32'(str_miss), 32'd0);
    chk("miss_next_load", 32'(ld), 32'h1234);

    // Zero mask walks the sequence without loading
    run_seq(9'h007, 16'h0000, -10, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("zero_load_or", 32'(ld_or), 32'd0);
    chk("zero_done_count", 32'(dc), 32'd1);
    chk("zero_latency", 32'(lat), 32'(21 + RB));

`ifdef IDLY_READBACK_EN
    corrupt_lane = 3; corrupt_val = 9'h002;
    run_seq(9'h003, 16'hFFFF, -10, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("rb_err_set", 32'(rb_err), 32'd1);
    corrupt_lane = -1;
    run_seq(9'h003, 16'hFFFF, -10, lat, lo, ld, cv, dc, en_and, ld_or);
    chk("rb_err_cleared", 32'(rb_err), 32'd0);
`endif

    // Reset during SETTLE with the strobe held high through release
    @(posedge tb_ACLK); #1;
    dly_val = 9'h044; lane_mask = 16'hFFFF; dly_str = 1'b1;
    repeat (2) @(posedge tb_ACLK); #1;
    dly_str = 1'b0;
    repeat (13) @(posedge tb_ACLK); #1;
    rstn = 1'b0; dly_str = 1'b1;
    @(negedge tb_ACLK);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    @(negedge tb_ACLK);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_en_vtc", 32'(idly_en_vtc), 32'hFFFF);
    chk("midrst_load", 32'(idly_load), 32'd0);
    @(posedge tb_ACLK); #1;
    rstn = 1'b1;
    busy_seen = 1'b0;
    repeat (12) begin
      @(negedge tb_ACLK);
      if (busy) busy_seen = 1'b1;
    end
    chk("midrst_no_restart", 32'(busy_seen), 32'd0);
    @(posedge tb_ACLK); #1;
    dly_str = 1'b0;

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      @(posedge tb_ACLK); #1;
      if ($urandom_range(0, 9) == 0) dly_str = ~dly_str;
      dly_val   = 9'($urandom);
      lane_mask = ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom);
      rstn      = ($urandom_range(0, 299) != 0);
      corrupt_lane = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NL - 1)) : -1;
      corrupt_val  = 9'($urandom);
    end
    @(posedge tb_ACLK); #1;
    rstn = 1'b1; dly_str = 1'b0; corrupt_lane = -1;
    repeat (30) @(posedge tb_ACLK);
    @(negedge tb_ACLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
